ycbcr2rgb: RTL

- Pipelined YCbCr 4:4:4 to RGB888 converter; the inverse of the RGB-to-YCbCr front end in the camera/gesture image path.
- Sits after YCbCr-domain processing (skin mask, filtering, overlay) and before the display/HDMI RGB sink.
- Carries vsync/clken/valid sideband and the original YCbCr pixel through the pipeline, time-aligned with the RGB result.
- Fixed 3-cycle latency, one pixel per clock, no backpressure.

---
 rtl/ycbcr_pkg.sv | 29 ++
 rtl/ycbcr2rgb_sat_u8.sv | 23 ++
 rtl/ycbcr2rgb.sv | 119 +++++++++++
 3 files changed

// File: rtl/ycbcr_pkg.sv
// Shared constants and types for the YCbCr 4:4:4 to RGB888 conversion path.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package ycbcr_pkg;

    // Q8 colour-difference coefficients (1.402, 0.344, 0.714, 1.772 scaled by 256)
    localparam int K_R_CR    = 359;
    localparam int K_G_CB    = 88;
    localparam int K_G_CR    = 183;
    localparam int K_B_CB    = 454;

    localparam int OFFSET_C  = 128;
    localparam int ROUND     = 128;
    localparam int FRAC_BITS = 8;
    localparam int PIPE_LAT  = 3;

    // Widest product is 454*-128 = -58112, so 18 signed bits cover every product.
    localparam int PROD_W    = 18;
    // Sums span -58112..123066; 19 signed bits leave headroom with no overflow.
    localparam int SUM_W     = 19;
    // Integer part of a sum after dropping the fraction bits.
    localparam int SAT_W     = SUM_W - FRAC_BITS;

    localparam int PIX_W     = 24;

    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [SUM_W-1:0]  sum_t;

endpackage

// File: rtl/ycbcr2rgb_sat_u8.sv
// Clamp of a signed integer to the unsigned 8-bit range 0..255.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of the input.
module sat_u8
    import ycbcr_pkg::*;
#(
    parameter int IN_W = SAT_W
) (
    input  logic signed [IN_W-1:0] din,
    output logic        [7:0]      dout
);

    // Negative values floor at 0; anything with bits above bit 7 saturates at 255.
    always_comb begin
        dout = din[7:0];
        if (din[IN_W-1]) begin
            dout = 8'h00;
        end else if (|din[IN_W-2:8]) begin
            dout = 8'hFF;
        end
    end

endmodule

// File: rtl/ycbcr2rgb.sv
// Pipelined YCbCr 4:4:4 to RGB888 converter with time-aligned sideband and source pixel.
// Latency: fixed 3 cycles, one pixel per clock.
// Backpressure: none; free-running pipeline, clken/valid are only delayed.
module ycbcr2rgb
    import ycbcr_pkg::*;
#(
    parameter bit BLANK_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ycbcr_vsync,
    input  logic             ycbcr_clken,
    input  logic             ycbcr_valid,
    input  logic [PIX_W-1:0] ycbcr_data,
    output logic             rgb_vsync,
    output logic             rgb_clken,
    output logic             rgb_valid,
    output logic [PIX_W-1:0] rgb_data,
    output logic [PIX_W-1:0] ycbcr_data_syn
);

    localparam prod_t K_R_CR_P = PROD_W'(K_R_CR);
    localparam prod_t K_G_CB_P = PROD_W'(K_G_CB);
    localparam prod_t K_G_CR_P = PROD_W'(K_G_CR);
    localparam prod_t K_B_CB_P = PROD_W'(K_B_CB);
    localparam sum_t  ROUND_S  = SUM_W'(ROUND);

    // Centred chroma, -128..127
    logic signed [8:0] cb_s;
    logic signed [8:0] cr_s;
    prod_t             cb_x;
    prod_t             cr_x;

    assign cb_s = 9'($signed({1'b0, ycbcr_data[15:8]}) - OFFSET_C);
    assign cr_s = 9'($signed({1'b0, ycbcr_data[7:0]}) - OFFSET_C);
    assign cb_x = PROD_W'(cb_s);
    assign cr_x = PROD_W'(cr_s);

    // Stage 1: luma in Q8 and the four chroma products
    logic [15:0] y_sh;
    prod_t       rcr;
    prod_t       gcb;
    prod_t       gcr;
    prod_t       bcb;

    // Stage 2: rounded Q8 channel sums
    sum_t        y_ext;
    sum_t        r_sum;
    sum_t        g_sum;
    sum_t        b_sum;

    assign y_ext = $signed({3'b000, y_sh});

    // Stage 3: integer part (floor) clamped to 8 bits
    logic [7:0]  r_sat;
    logic [7:0]  g_sat;
    logic [7:0]  b_sat;
    logic [PIX_W-1:0] rgb_q;

    // Sideband and source pixel delay lines
    logic [PIPE_LAT-1:0]       vsync_sr;
    logic [PIPE_LAT-1:0]       clken_sr;
    logic [PIPE_LAT-1:0]       valid_sr;
    logic [PIPE_LAT*PIX_W-1:0] data_sr;

    // Arithmetic pipeline: products, sums, then clamped result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_sh  <= '0;
            rcr   <= '0;
            gcb   <= '0;
            gcr   <= '0;
            bcb   <= '0;
            r_sum <= '0;
            g_sum <= '0;
            b_sum <= '0;
            rgb_q <= '0;
        end else begin
            y_sh  <= {ycbcr_data[23:16], 8'h00};
            rcr   <= K_R_CR_P * cr_x;
            gcb   <= K_G_CB_P * cb_x;
            gcr   <= K_G_CR_P * cr_x;
            bcb   <= K_B_CB_P * cb_x;
            r_sum <= y_ext + SUM_W'(rcr) + ROUND_S;
            g_sum <= y_ext - SUM_W'(gcb) - SUM_W'(gcr) + ROUND_S;
            b_sum <= y_ext + SUM_W'(bcb) + ROUND_S;
            rgb_q <= {r_sat, g_sat, b_sat};
        end
    end

    // Taking the top bits of a sum is the arithmetic shift right by FRAC_BITS.
    sat_u8 #(.IN_W(SAT_W)) u_sat_r (.din($signed(r_sum[SUM_W-1:FRAC_BITS])), .dout(r_sat));
    sat_u8 #(.IN_W(SAT_W)) u_sat_g (.din($signed(g_sum[SUM_W-1:FRAC_BITS])), .dout(g_sat));
    sat_u8 #(.IN_W(SAT_W)) u_sat_b (.din($signed(b_sum[SUM_W-1:FRAC_BITS])), .dout(b_sat));

    // Sideband and original pixel follow the arithmetic by exactly PIPE_LAT cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_sr <= '0;
            clken_sr <= '0;
            valid_sr <= '0;
            data_sr  <= '0;
        end else begin
            vsync_sr <= {vsync_sr[PIPE_LAT-2:0], ycbcr_vsync};
            clken_sr <= {clken_sr[PIPE_LAT-2:0], ycbcr_clken};
            valid_sr <= {valid_sr[PIPE_LAT-2:0], ycbcr_valid};
            data_sr  <= {data_sr[(PIPE_LAT-1)*PIX_W-1:0], ycbcr_data};
        end
    end

    assign rgb_vsync      = vsync_sr[PIPE_LAT-1];
    assign rgb_clken      = clken_sr[PIPE_LAT-1];
    assign rgb_valid      = valid_sr[PIPE_LAT-1];
    assign ycbcr_data_syn = data_sr[PIPE_LAT*PIX_W-1 -: PIX_W];

    // Blank the pixel bus outside active clken so the sink sees black between pixels.
    assign rgb_data = (BLANK_ZERO && !rgb_clken) ? '0 : rgb_q;

endmodule
